// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, FSM encoding and rotate helper for the SHA-256 message schedule
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_sigma.sv
// rtl/sha256_sigma.sv - combinational small-sigma0 and small-sigma1 functions of SHA-256
module sha256_sigma
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] s0_x,
  input  logic [WORD_W-1:0] s1_x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = rotr(s0_x, S0_ROT_A) ^ rotr(s0_x, S0_ROT_B) ^ (s0_x >> S0_SHR);
  assign s1 = rotr(s1_x, S1_ROT_A) ^ rotr(s1_x, S1_ROT_B) ^ (s1_x >> S1_SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule: loads M[0..15], expands W[16..63] with valid/ready output
module sha256_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic [WORD_W-1:0] w_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [5:0]        t_o,
  output logic              done_o
);

  // index must reach ROUNDS to mark "all words produced"
  localparam int IDX_W = $clog2(ROUNDS + 1);

  sha256_pkg::state_t state_q, state_d;

  logic [IDX_W-1:0]  index_q;
  // win_q[15] is W[t-1] (newest), win_q[0] is W[t-16] (oldest)
  logic [WORD_W-1:0] win_q [16];

  logic              slot_free;
  logic              load_xfer;
  logic              exp_fire;
  logic              new_word;
  logic              last_take;
  logic [WORD_W-1:0] sig0, sig1;
  logic [WORD_W-1:0] expanded;
  logic [WORD_W-1:0] new_data;

  assign slot_free = !w_valid_o || w_ready_i;
  assign load_xfer = word_valid_i && word_ready_o;
  assign exp_fire  = (state_q == sha256_pkg::ST_EXPAND) && slot_free &&
                     (index_q != IDX_W'(ROUNDS));
  assign new_word  = load_xfer || exp_fire;
  assign last_take = w_valid_o && w_ready_i && (t_o == 6'(ROUNDS - 1));

  sha256_sigma u_sigma (
    .s0_x (win_q[1]),
    .s1_x (win_q[14]),
    .s0   (sig0),
    .s1   (sig1)
  );

  // W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32
  assign expanded = sig1 + win_q[9] + sig0 + win_q[0];
  assign new_data = (state_q == sha256_pkg::ST_LOAD) ? word_i : expanded;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= sha256_pkg::ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      sha256_pkg::ST_IDLE:   if (start) state_d = sha256_pkg::ST_LOAD;
      sha256_pkg::ST_LOAD:   if (load_xfer && (index_q == IDX_W'(15))) state_d = sha256_pkg::ST_EXPAND;
      sha256_pkg::ST_EXPAND: if (last_take) state_d = sha256_pkg::ST_DONE;
      sha256_pkg::ST_DONE:   state_d = sha256_pkg::ST_IDLE;
      default:               state_d = sha256_pkg::ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    word_ready_o = (state_q == sha256_pkg::ST_LOAD) && slot_free;
    done_o       = (state_q == sha256_pkg::ST_DONE);
  end

  // window, index and output register; everything holds while the output is stalled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      index_q   <= '0;
      w_o       <= '0;
      t_o       <= '0;
      w_valid_o <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      if ((state_q == sha256_pkg::ST_IDLE) && start) begin
        index_q <= '0;
      end
      if (new_word) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= new_data;
        w_o       <= new_data;
        t_o       <= index_q[5:0];
        w_valid_o <= 1'b1;
        index_q   <= index_q + 1'b1;
      end else if (w_ready_i) begin
        w_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - directed self-checking bench for sha256_msg_sched
module tb_sha256_msg_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] w_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [5:0]  t_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [$];
  int          got_t [$];
  int          got_c [$];

  always #5 CLK = ~CLK;

  sha256_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .w_o          (w_o),
    .w_valid_o    (w_valid_o),
    .w_ready_i    (w_ready_i),
    .t_o          (t_o),
    .done_o       (done_o)
  );

  // cycle counter for throughput measurement
  always @(posedge CLK) cyc <= cyc + 1;

  // record every consumed output word and every done pulse, away from the active edge
  always @(negedge CLK) begin
    if (!RST && w_valid_o && w_ready_i) begin
      got_w.push_back(w_o);
      got_t.push_back(int'(t_o));
      got_c.push_back(cyc);
    end
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic set_msg(input bit abc);
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    if (abc) begin
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
    end
    for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    got_w.delete();
    got_t.delete();
    got_c.delete();
    done_cnt = 0;
  endtask

  task automatic feed(input bit toggle);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (i < 16 && guard < 200) begin
      word_i       = msg[i];
      word_valid_i = toggle ? ((guard % 2) == 1) : 1'b1;
      @(negedge CLK);
      acc = word_valid_i && word_ready_o;
      tick();
      if (acc) i++;
      guard++;
    end
    word_valid_i = 1'b0;
    word_i       = 32'h0;
    check("load_count", 32'(i), 32'd16);
  endtask

  task automatic finish_run(input int stall_t, input int start_t, input int rst_t, output bit aborted);
    int guard = 0;
    bit stalled = 0;
    aborted = 0;
    while (done_cnt == 0 && guard < 300 && !aborted) begin
      if (w_valid_o && int'(t_o) == stall_t && !stalled) begin
        stalled   = 1;
        w_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          check("stall_w",     w_o, exp_w[20]);
          check("stall_t",     32'(t_o), 32'd20);
          check("stall_valid", 32'(w_valid_o), 32'd1);
          check("stall_wrdy",  32'(word_ready_o), 32'd0);
        end
        w_ready_i = 1'b1;
      end else if (w_valid_o && int'(t_o) == start_t) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else if (w_valid_o && int'(t_o) == rst_t) begin
        RST = 1'b1;
        #1;
        check("rst_async_w",     w_o, 32'h0);
        check("rst_async_valid", 32'(w_valid_o), 32'd0);
        tick();
        check("rst_w",     w_o, 32'h0);
        check("rst_t",     32'(t_o), 32'd0);
        check("rst_valid", 32'(w_valid_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_wrdy",  32'(word_ready_o), 32'd0);
        RST = 1'b0;
        aborted = 1;
      end else begin
        tick();
      end
      guard++;
    end
    if (!aborted) begin
      check("done_seen", 32'(done_cnt > 0), 32'd1);
      tick();
      tick();
      tick();
      check("done_once",  32'(done_cnt), 32'd1);
      check("idle_valid", 32'(w_valid_o), 32'd0);
      check("idle_wrdy",  32'(word_ready_o), 32'd0);
    end
  endtask

  task automatic check_seq(input string name, input bit timing);
    check({name, "_count"}, 32'(got_w.size()), 32'd64);
    for (int i = 0; i < 64 && i < got_w.size(); i++) begin
      check($sformatf("%s_t%0d", name, i), 32'(got_t[i]), 32'(i));
      check($sformatf("%s_w%0d", name, i), got_w[i], exp_w[i]);
    end
    if (timing && got_w.size() == 64)
      check({name, "_cycles"}, 32'(got_c[63] - got_c[0]), 32'd63);
  endtask

  initial begin
    bit ab;
    RST          = 1'b1;
    start        = 1'b0;
    word_i       = 32'h0;
    word_valid_i = 1'b0;
    w_ready_i    = 1'b1;
    tick();
    tick();
    check("reset_w",     w_o, 32'h0);
    check("reset_t",     32'(t_o), 32'd0);
    check("reset_valid", 32'(w_valid_o), 32'd0);
    check("reset_done",  32'(done_o), 32'd0);
    check("reset_wrdy",  32'(word_ready_o), 32'd0);
    RST = 1'b0;
    tick();

    // words offered while idle are not accepted
    word_valid_i = 1'b1;
    word_i       = 32'hDEADBEEF;
    tick();
    check("idle_no_ready", 32'(word_ready_o), 32'd0);
    check("idle_no_out",   32'(w_valid_o), 32'd0);
    word_valid_i = 1'b0;
    tick();

    // padded "abc" block at full throughput
    set_msg(1);
    clear_mon();
    feed(0);
    finish_run(-1, -1, -1, ab);
    check_seq("abc", 1);
    if (got_w.size() == 64) begin
      check("abc_w16", got_w[16], 32'h61626380);
      check("abc_w17", got_w[17], 32'h000F0000);
      check("abc_w18", got_w[18], 32'h7DA86405);
    end

    // all-zero block
    set_msg(0);
    clear_mon();
    feed(0);
    finish_run(-1, -1, -1, ab);
    check_seq("zero", 1);

    // downstream stall at t=20
    set_msg(1);
    clear_mon();
    feed(0);
    finish_run(20, -1, -1, ab);
    check_seq("stall", 0);

    // start pulse mid-expansion is ignored
    set_msg(1);
    clear_mon();
    feed(0);
    finish_run(-1, 30, -1, ab);
    check_seq("midstart", 1);

    // reset at t=40 aborts with no done pulse
    set_msg(1);
    clear_mon();
    feed(0);
    finish_run(-1, -1, 40, ab);
    check("rst_aborted", 32'(ab), 32'd1);
    tick();
    tick();
    check("rst_no_done",   32'(done_cnt), 32'd0);
    check("rst_idle_wrdy", 32'(word_ready_o), 32'd0);
    check("rst_idle_valid", 32'(w_valid_o), 32'd0);

    // fresh "abc" after the aborted block
    clear_mon();
    feed(0);
    finish_run(-1, -1, -1, ab);
    check_seq("after_rst", 1);

    // input valid toggled every other cycle during load
    set_msg(1);
    clear_mon();
    feed(1);
    finish_run(-1, -1, -1, ab);
    check_seq("toggle", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 The module SHALL have parameter WORD_W, default 32, meaning SHA-256 word width; only 32 is supported.
REQ-002 The module SHALL have parameter ROUNDS, default 64, meaning the number of schedule words W[t] produced per block.
REQ-003 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse that begins a new 512-bit block; sampled only in IDLE.
REQ-006 word_i  input  32  message word M[t], big-endian word order, t = 0..15.
REQ-007 word_valid_i  input  1  word_i is valid.
REQ-008 word_ready_o  output  1  block accepts word_i this cycle.
REQ-009 w_o  output  32  schedule word W[t] for the downstream round register.
REQ-010 w_valid_o  output  1  w_o and t_o are valid.
REQ-011 w_ready_i  input  1  downstream consumes w_o this cycle.
REQ-012 t_o  output  6  round index of w_o, 0..63.
REQ-013 done_o  output  1  one-cycle pulse after W[63] is consumed.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, EXPAND and DONE.
REQ-015 IDLE -> LOAD SHALL occur on start=1; the internal index SHALL clear to 0 on that edge.
REQ-016 start SHALL be ignored in LOAD, EXPAND and DONE.
REQ-017 Output slot free (slot_free) SHALL be defined as !w_valid_o || w_ready_i.
REQ-018 word_ready_o SHALL be 1 only in LOAD with slot_free; it SHALL be 0 in every other state.
REQ-019 In LOAD, a transfer (word_valid_i && word_ready_o) SHALL on that edge: shift word_i into a 16-entry window, set w_o=word_i, set t_o=index, set w_valid_o=1, and increment index.
REQ-020 After the 16th LOAD transfer (t=15), the FSM SHALL go to EXPAND.
REQ-021 In EXPAND, each cycle with slot_free SHALL produce W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], taken modulo 2^32, for t = 16..63.
REQ-022 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-023 sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-024 Each EXPAND word SHALL be shifted into the window and presented on w_o/t_o with w_valid_o=1.
REQ-025 Latency SHALL be one cycle from an accepted input word, or from a free slot in EXPAND, to valid w_o.
REQ-026 Sustained throughput SHALL be one word per cycle while w_ready_i=1.
REQ-027 While w_valid_o=1 and w_ready_i=0, w_o, t_o, the window and index SHALL hold unchanged.
REQ-028 When W[63] is consumed (w_valid_o && w_ready_i && t_o==63), the FSM SHALL go to DONE and w_valid_o SHALL clear unless a new word is loaded on the same edge.
REQ-029 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-030 Consumption of the final word in the same cycle as a new input transfer SHALL be impossible, because LOAD occurs only after start.

Reset
REQ-031 On RST=1, the FSM SHALL go to IDLE, index and t_o SHALL be 0, w_o SHALL be 0, w_valid_o, done_o and word_ready_o SHALL be 0, and all window entries SHALL be 0.
REQ-032 RST asserted mid-LOAD or mid-EXPAND SHALL abort the block with no done_o pulse; a new start SHALL be required.

Structure
REQ-033 A shared package sha256_pkg SHALL hold WORD_W, ROUNDS, the rotation/shift constants (7, 18, 3, 17, 19, 10) and the FSM state encoding.
REQ-034 One combinational sub-module, sha256_sigma, SHALL compute both sigma0 and sigma1 and SHALL be instantiated once.

Verification
REQ-035 Padded "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready_i=1 -> t_o steps 0..63 on consecutive cycles, W16=0x61626380, W17=0x000F0000, and a single done_o pulse follows.
REQ-036 All-zero block -> all 64 W outputs are 0x00000000, and done_o pulses once.
REQ-037 w_ready_i=0 for 5 cycles at t=20 -> w_o and t_o=20 hold stable, word_ready_o=0, and the sequence resumes with t=21 and no word lost or duplicated.
REQ-038 start pulsed at t=30 mid-EXPAND -> no effect, and the output sequence is identical to REQ-035.
REQ-039 RST asserted at t=40 -> next cycle all outputs are 0 and the FSM is in IDLE, with no done_o; a subsequent start with "abc" reproduces REQ-035.
REQ-040 word_valid_i toggled every other cycle during LOAD -> exactly 16 words are accepted in order, and the expansion results match REQ-035.
